// File: rtl/sincos_tbl_pkg.sv
// Shared types and default geometry for the sine/cosine table loader.
package sincos_tbl_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [MASK_W-1:0] WMASK_ALL = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sincos_table_loader_if.sv
// Valid/ready stream of (sin, cos) sample pairs feeding the table loader.
interface sincos_table_loader_if #(
    parameter int unsigned DW = sincos_tbl_pkg::DATA_W
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_sin;
    logic [DW-1:0] s_cos;

    modport master (output s_valid, output s_sin, output s_cos, input s_ready);
    modport slave  (input s_valid, input s_sin, input s_cos, output s_ready);
endinterface

// File: rtl/tbl_addr_ctr.sv
// Table write-address counter with clear, enable and terminal count at DEPTH-1.
module tbl_addr_ctr #(
    parameter int unsigned ADDR_W = sincos_tbl_pkg::ADDR_W,
    parameter int unsigned DEPTH  = sincos_tbl_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              tc_c
);

    // Natural ADDR_W wrap takes DEPTH-1 back to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + ADDR_W'(1);
        end
    end

    assign tc_c = (count == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/sincos_table_loader.sv
// Streams (sin, cos) pairs into SRAM port 0 at addresses 0..DEPTH-1, then opens reader port 1.
// Optional running XOR-sum checksum: define SINCOS_TABLE_LOADER_CHECKSUM_EN.
module sincos_table_loader #(
    parameter int unsigned ADDR_W = sincos_tbl_pkg::ADDR_W,
    parameter int unsigned DEPTH  = sincos_tbl_pkg::DEPTH,
    parameter int unsigned DATA_W = sincos_tbl_pkg::DATA_W,
    parameter int unsigned MASK_W = sincos_tbl_pkg::MASK_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    sincos_table_loader_if.slave s,
    output logic                csb0,
    output logic                web0,
    output logic [MASK_W-1:0]   wmask0,
    output logic [ADDR_W-1:0]   addr0,
    output logic [DATA_W-1:0]   din00,
    output logic [DATA_W-1:0]   din01,
    output logic                csb1,
    output logic                busy,
    output logic                done
`ifdef SINCOS_TABLE_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum,
    output logic                checksum_valid
`endif
);
    import sincos_tbl_pkg::*;

    state_t              state, state_n;
    logic                csb0_n, web0_n, csb1_n, busy_n, done_n, ready_n;
    logic [MASK_W-1:0]   wmask0_n;
    logic [ADDR_W-1:0]   addr0_n;
    logic [DATA_W-1:0]   din00_n, din01_n;
    logic                ctr_clear, ctr_en, ctr_tc;
    logic [ADDR_W-1:0]   ctr_count;

    tbl_addr_ctr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .clear (ctr_clear),
        .en    (ctr_en),
        .count (ctr_count),
        .tc_c  (ctr_tc)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            wmask0    <= '0;
            addr0     <= '0;
            din00     <= '0;
            din01     <= '0;
            s.s_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            csb1      <= 1'b1;
        end else begin
            state     <= state_n;
            csb0      <= csb0_n;
            web0      <= web0_n;
            wmask0    <= wmask0_n;
            addr0     <= addr0_n;
            din00     <= din00_n;
            din01     <= din01_n;
            s.s_ready <= ready_n;
            busy      <= busy_n;
            done      <= done_n;
            csb1      <= csb1_n;
        end
    end

    // Next state and next register values; port 0 idles unless a pair was accepted.
    always_comb begin
        state_n   = state;
        csb0_n    = 1'b1;
        web0_n    = 1'b1;
        wmask0_n  = '0;
        addr0_n   = addr0;
        din00_n   = din00;
        din01_n   = din01;
        ready_n   = s.s_ready;
        busy_n    = busy;
        done_n    = 1'b0;
        csb1_n    = csb1;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    // Close the reader port before any rewrite reaches port 0.
                    state_n   = LOAD;
                    busy_n    = 1'b1;
                    ready_n   = 1'b1;
                    csb1_n    = 1'b1;
                    ctr_clear = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n   = IDLE;
                    busy_n    = 1'b0;
                    ready_n   = 1'b0;
                    csb1_n    = 1'b1;
                    ctr_clear = 1'b1;
                end else if (!s.s_ready) begin
                    // Ready is only dropped while the final write is on port 0.
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    csb1_n  = 1'b0;
                end else if (s.s_valid) begin
                    csb0_n   = 1'b0;
                    web0_n   = 1'b0;
                    wmask0_n = MASK_W'(WMASK_ALL);
                    addr0_n  = ctr_count;
                    din00_n  = s.s_sin;
                    din01_n  = s.s_cos;
                    ctr_en   = 1'b1;
                    if (ctr_tc) begin
                        ready_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef SINCOS_TABLE_LOADER_CHECKSUM_EN
    logic load_req_c, abort_c;
    assign load_req_c = start && (state != LOAD);
    assign abort_c    = abort && (state == LOAD);

    // Wrapping sum of sin^cos over accepted pairs; valid from done until restart/abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum       <= '0;
            checksum_valid <= 1'b0;
        end else if (load_req_c) begin
            checksum       <= '0;
            checksum_valid <= 1'b0;
        end else begin
            if (ctr_en) begin
                checksum <= checksum + (s.s_sin ^ s.s_cos);
            end
            if (done_n) begin
                checksum_valid <= 1'b1;
            end else if (abort_c) begin
                checksum_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/sincos_table_loader.md
Name: sincos_table_loader

Overview:
- Write-side master for the 512-entry sine/cosine lookup SRAM that the phase counter reads.
- Accepts a valid/ready stream of (sin, cos) sample pairs and drives SRAM port 0 (csb0/web0/wmask0/addr0/din00/din01) sequentially from address 0 to DEPTH-1.
- After the last write it releases port 0 and enables the reader port via csb1.
- Replaces bench-driven table initialisation with a synthesizable loader.

Parameters:
- ADDR_W, 9, SRAM address width.
- DEPTH, 512, number of table entries; must equal 2**ADDR_W.
- DATA_W, 32, width of each sine/cosine word.
- MASK_W, 4, write-mask width; must equal DATA_W/8.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to (re)load the table.
- abort  in  1  cancels a load in progress.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  loader accepts a pair this cycle.
- s_sin  in  DATA_W  sine sample.
- s_cos  in  DATA_W  cosine sample.
- csb0  out  1  port-0 chip select, active-low.
- web0  out  1  port-0 write enable, active-low.
- wmask0  out  MASK_W  port-0 byte write mask.
- addr0  out  ADDR_W  port-0 address.
- din00  out  DATA_W  sine table write data.
- din01  out  DATA_W  cosine table write data.
- csb1  out  1  reader-port chip select, active-low; low only while the table is valid.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the last entry has been written.

Behaviour:
- Reset values (reset low at a clk edge): state IDLE, csb0=1, web0=1, wmask0=0, addr0=0, din00=0, din01=0, s_ready=0, busy=0, done=0, csb1=1, internal address counter=0.
- All outputs are registered.
- States:
  - IDLE: s_ready=0. start moves to LOAD with counter=0.
  - LOAD: busy=1, s_ready=1.
  - DONE: csb1=0, s_ready=0.
- Write timing:
  - A pair is accepted on a cycle where s_valid=1 and s_ready=1.
  - In the next cycle csb0=0, web0=0, wmask0=all ones, addr0=counter, din00=s_sin, din01=s_cos.
  - The SRAM samples these on the following edge, so write latency is 1 cycle from acceptance.
  - The counter increments by 1 per acceptance.
- Bubbles: a LOAD cycle with s_valid=0 drives csb0=1, web0=1, wmask0=0 in the next cycle. addr0/din hold their last values. No write occurs.
- Last entry:
  - On acceptance with counter=DEPTH-1, s_ready drops in the next cycle while that final write is presented.
  - The cycle after the final write: csb0=1, web0=1, done=1 for one cycle, busy=0, csb1=0, state DONE.
  - The counter wraps to 0; addr0 never exceeds DEPTH-1.
- Re-load: start in DONE moves to LOAD. csb1 goes to 1 in the next cycle, before any port-0 write, so the reader never sees a partially rewritten table.
- start while in LOAD is ignored.
- abort:
  - In LOAD: next cycle goes to IDLE with csb0=1, web0=1, busy=0, csb1=1, no done pulse. An acceptance in the same cycle as abort is discarded.
  - In IDLE or DONE: abort has no effect.
  - start and abort together in IDLE or DONE: abort wins only if state is LOAD; otherwise start is honoured.
- Port-0 writes and csb1=0 are never active in the same cycle.
- Mid-load reset: all reset values apply at that edge, and the partial table is treated as invalid (csb1=1).

Optional Feature:
- Macro: SINCOS_TABLE_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum (DATA_W) and checksum_valid (1).
  - checksum = wrapping sum modulo 2**DATA_W of (s_sin XOR s_cos) over all accepted pairs. It is cleared at start and at reset.
  - checksum_valid rises with done and falls at the next start or on abort.
- When undefined: neither port exists and no accumulator logic is synthesized.

Decomposition:
- Shared package sincos_tbl_pkg holds:
  - ADDR_W, DATA_W, DEPTH, MASK_W defaults;
  - the state enum (IDLE, LOAD, DONE);
  - the all-ones write-mask constant.
- One sub-module: tbl_addr_ctr, an ADDR_W up-counter with clear, enable and terminal-count (==DEPTH-1) output.
- The FSM and port-0 output registers stay in the top.

Test Plan:
- Reset held 3 cycles then released: csb0=1, web0=1, csb1=1, busy=0, done=0. start with a continuous stream s_sin=i, s_cos=~i for 512 pairs: 512 consecutive writes at addr0=0..511 carrying matching data. done pulses once 1 cycle after addr0=511. csb1=0 from that cycle onward.
- Insert s_valid=0 every 3rd cycle: writes occur only on the cycle after each acceptance, addresses stay contiguous, final contents are identical to the first scenario.
- abort after 100 acceptances: csb0=1 next cycle, busy=0, no done, csb1=1. A fresh start then writes addr0 from 0.
- start in DONE: csb1=1 on the next cycle, before the first write to addr0=0. start pulsed again at address 200 is ignored.
- reset low at address 300: all outputs at reset values on the next cycle. A subsequent start reloads from 0.
- With SINCOS_TABLE_LOADER_CHECKSUM_EN: 512 pairs with s_sin=1, s_cos=0 give checksum=512 and checksum_valid=1 together with done.
